// File: rtl/gen_phv_conf_parser_v2.sv
// gen_phv_conf_parser_v2: forwards data packets, builds a PHV from leading words, and turns config packets into serialized rule writes.
module gen_phv_conf_parser_v2 #(
   parameter int          DW            = 128,
   parameter int          PHV_WIDTH     = 1024,
   parameter int          PKT_NUM       = PHV_WIDTH / DW,
   parameter logic [15:0] CONF_ETYPE    = 16'h9006,
   parameter int          RULE_PER_WORD = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_pkt_valid,
   input  logic [DW+5:0]        i_pkt,
   output logic                 o_in_ready,
   input  logic [7:0]           i_inport,
   output logic                 o_pkt_valid,
   output logic [DW+5:0]        o_pkt,
   output logic                 o_phv_valid,
   input  logic                 i_phv_ready,
   output logic [PHV_WIDTH-1:0] o_phv,
   output logic                 o_rule_wren,
   output logic [31:0]          o_rule_addr,
   output logic [31:0]          o_rule_wdata,
   output logic [15:0]          o_err_cnt,
   output logic [15:0]          o_phv_drop_cnt
);
   localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, CONF = 2'd2, CONF_SER = 2'd3;
   localparam int CW = $clog2(PKT_NUM + 1);
   localparam int RW = RULE_PER_WORD;

   logic [1:0]           state;
   logic [CW-1:0]        cnt;
   logic [PHV_WIDTH-1:0] build, build_nxt;
   logic [DW-1:0]        data, conf_word, src_word;
   logic [RW-1:0]        pend, slot_ok, src_mask, rest;
   logic [31:0]          sel_addr, sel_data;
   logic [1:0]           tag;
   logic                 conf_last, acc, head, inv, bt, conf_et, fwd, conf_in, fire, phv_done, err_inc;

   assign tag        = i_pkt[DW+5:DW+4];
   assign data       = i_pkt[DW-1:0];
   assign o_in_ready = state != CONF_SER;
   assign acc        = i_pkt_valid & o_in_ready;
   assign head       = tag == 2'b01;
   assign inv        = tag == 2'b00;
   assign bt         = tag[1];
   assign conf_et    = data[31:16] == CONF_ETYPE;
   assign fwd        = (head & !conf_et) | (bt & state == DATA);
   assign conf_in    = acc & bt & state == CONF;
   assign phv_done   = acc & tag == 2'b10 & state == DATA;
   assign err_inc    = acc & (inv | (head & (state == DATA | state == CONF)) | (bt & state == IDLE));
   assign src_word   = state == CONF_SER ? conf_word : data;
   assign src_mask   = state == CONF_SER ? pend : slot_ok;
   assign rest       = src_mask & (src_mask - RW'(1));
   assign fire       = state == CONF_SER | conf_in;

   // Bits [15:8] carry the ingress port and survive every later slice write.
   always_comb begin
      build_nxt = build;
      if (head) begin
         build_nxt = '0;
         build_nxt[PHV_WIDTH-1 -: DW] = data;
         build_nxt[15:8] = i_inport;
      end else begin
         for (int n = 1; n < PKT_NUM; n++)
            if (cnt == CW'(n)) build_nxt[PHV_WIDTH-1-DW*n -: DW] = data;
         build_nxt[15:8] = build[15:8];
      end
   end

   always_comb begin
      slot_ok = '0;
      for (int k = 0; k < RW; k++) slot_ok[k] = data[16+64*k +: 32] != 32'hFFFF_FFFF;
   end

   // Descending scan so the lowest pending slot wins.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int k = RW - 1; k >= 0; k--)
         if (src_mask[k]) begin
            sel_addr = src_word[16+64*k +: 32];
            sel_data = src_word[48+64*k +: 32];
         end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state          <= IDLE;
         cnt            <= '0;
         build          <= '0;
         conf_word      <= '0;
         pend           <= '0;
         conf_last      <= 1'b0;
         o_pkt_valid    <= 1'b0;
         o_pkt          <= '0;
         o_phv_valid    <= 1'b0;
         o_phv          <= '0;
         o_rule_wren    <= 1'b0;
         o_rule_addr    <= '0;
         o_rule_wdata   <= '0;
         o_err_cnt      <= '0;
         o_phv_drop_cnt <= '0;
      end else begin
         o_pkt_valid <= acc & fwd;
         if (acc & fwd) begin
            o_pkt <= i_pkt;
            build <= build_nxt;
            cnt   <= head ? CW'(1) : (cnt < CW'(PKT_NUM) ? cnt + CW'(1) : cnt);
         end
         o_rule_wren <= fire & |src_mask;
         if (fire & |src_mask) begin
            o_rule_addr  <= sel_addr;
            o_rule_wdata <= sel_data;
         end
         if (err_inc && o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
         if (phv_done) begin
            if (o_phv_valid & !i_phv_ready) begin
               if (o_phv_drop_cnt != 16'hFFFF) o_phv_drop_cnt <= o_phv_drop_cnt + 16'd1;
            end else begin
               o_phv_valid <= 1'b1;
               o_phv       <= build_nxt;
            end
         end else if (i_phv_ready) o_phv_valid <= 1'b0;
         if (state == CONF_SER) begin
            pend <= rest;
            if (rest == '0) state <= conf_last ? IDLE : CONF;
         end else if (acc & !inv) begin
            if (head) state <= conf_et ? CONF : DATA;
            else if (state == DATA & !tag[0]) state <= IDLE;
            else if (state == CONF) begin
               conf_word <= data;
               pend      <= rest;
               conf_last <= !tag[0];
               state     <= rest != '0 ? CONF_SER : (tag[0] ? CONF : IDLE);
            end
         end
      end
   end
endmodule

// File: tb/tb_gen_phv_conf_parser_v2.sv
// tb_gen_phv_conf_parser_v2: table vectors, directed multi-cycle sequences and random packets against a whole-packet reference model.
module tb_gen_phv_conf_parser_v2;
   localparam int DW = 128;
   localparam int PW = 1024;
   localparam int PN = PW / DW;
   localparam int DB = 256;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst, pv, in_ready, pkt_valid, phv_valid, phv_ready, wren;
   logic [DW+5:0]  pkt, pkt_out;
   logic [7:0]     inport;
   logic [PW-1:0]  phv;
   logic [31:0]    addr, wdata;
   logic [15:0]    err_cnt, drop_cnt;
   logic           pv_b, in_ready_b, pkt_valid_b, phv_valid_b, phv_ready_b, wren_b;
   logic [DB+5:0]  pkt_b, pkt_out_b;
   logic [PW-1:0]  phv_b;
   logic [31:0]    addr_b, wdata_b;
   logic [15:0]    err_b, drop_b;

   gen_phv_conf_parser_v2 dut (
      .i_clk(clk), .i_rst(rst), .i_pkt_valid(pv), .i_pkt(pkt), .o_in_ready(in_ready),
      .i_inport(inport), .o_pkt_valid(pkt_valid), .o_pkt(pkt_out), .o_phv_valid(phv_valid),
      .i_phv_ready(phv_ready), .o_phv(phv), .o_rule_wren(wren), .o_rule_addr(addr),
      .o_rule_wdata(wdata), .o_err_cnt(err_cnt), .o_phv_drop_cnt(drop_cnt)
   );

   gen_phv_conf_parser_v2 #(.DW(DB), .PHV_WIDTH(PW), .RULE_PER_WORD(3)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_pkt_valid(pv_b), .i_pkt(pkt_b), .o_in_ready(in_ready_b),
      .i_inport(inport), .o_pkt_valid(pkt_valid_b), .o_pkt(pkt_out_b), .o_phv_valid(phv_valid_b),
      .i_phv_ready(phv_ready_b), .o_phv(phv_b), .o_rule_wren(wren_b), .o_rule_addr(addr_b),
      .o_rule_wdata(wdata_b), .o_err_cnt(err_b), .o_phv_drop_cnt(drop_b)
   );

   typedef struct { logic [DW+5:0] w; int c; } pkt_rec_t;
   typedef struct { logic [31:0] a; logic [31:0] d; int c; } rule_rec_t;
   typedef struct { logic [1:0] tag; logic [31:0] a; logic [31:0] d; logic w; logic e; } vec_t;

   int n_vec = 0, n_bad = 0, cyc = 0, acc_cyc = 0, ir_low_b = 0;
   pkt_rec_t  got_pkt[$];
   rule_rec_t got_rule[$], got_rule_b[$];
   logic [PW-1:0]   got_phv[$], exp_phv[$];
   logic [DW+5:0]   exp_pkt[$];
   logic [63:0]     exp_rule[$];
   logic [DW-1:0]   pw[$];
   vec_t            tbl[8];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (pkt_valid) got_pkt.push_back('{pkt_out, cyc});
      if (phv_valid && phv_ready) got_phv.push_back(phv);
      if (wren) got_rule.push_back('{addr, wdata, cyc});
      if (wren_b) got_rule_b.push_back('{addr_b, wdata_b, cyc});
      if (!in_ready_b) ir_low_b++;
   end

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_phv(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      for (int i = 0; i < PW / 128; i++)
         chk($sformatf("%s[%0d]", nm, i), 160'(act[PW-1-128*i -: 128]), 160'(exp[PW-1-128*i -: 128]));
   endtask

   task automatic send(input logic [1:0] tag, input logic [DW-1:0] d, input logic [3:0] be = 4'hF);
      logic r;
      int t;
      r = 1'b0;
      t = 0;
      pkt = {tag, be, d};
      pv = 1'b1;
      while (!r && t < 20) begin
         @(negedge clk);
         r = in_ready;
         acc_cyc = cyc;
         t++;
         @(posedge clk);
      end
      if (!r) chk("send_timeout", 160'(r), 160'(1));
      #1 pv = 1'b0;
   endtask

   task automatic send_b(input logic [1:0] tag, input logic [DB-1:0] d);
      logic r;
      int t;
      r = 1'b0;
      t = 0;
      pkt_b = {tag, 4'hF, d};
      pv_b = 1'b1;
      while (!r && t < 20) begin
         @(negedge clk);
         r = in_ready_b;
         acc_cyc = cyc;
         t++;
         @(posedge clk);
      end
      if (!r) chk("send_b_timeout", 160'(r), 160'(1));
      #1 pv_b = 1'b0;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      pv = 1'b0;
      pv_b = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      got_pkt.delete(); got_rule.delete(); got_rule_b.delete(); got_phv.delete();
      ir_low_b = 0;
   endtask

   function automatic logic [DW-1:0] hd(input logic [15:0] et, input logic [DW-1:0] r);
      hd = r;
      hd[31:16] = et;
   endfunction

   function automatic logic [DW-1:0] cw(input logic [31:0] a, input logic [31:0] d);
      cw = {48'hC0FFEE_123456, 80'h0};
      cw[47:16] = a;
      cw[79:48] = d;
   endfunction

   // Reference PHV: word i of the packet lands i word-widths below the top, port byte at [15:8].
   function automatic logic [PW-1:0] mkphv(input logic [7:0] ip);
      logic [PW-1:0] p, t;
      p = '0;
      for (int i = 0; i < pw.size() && i < PN; i++) begin
         t = '0;
         t[PW-1 -: DW] = pw[i];
         p = p | (t >> (DW * i));
      end
      p[15:8] = ip;
      return p;
   endfunction

   function automatic logic [DW-1:0] rnd_w();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [DW-1:0] w0, w1, w2, w3;
   logic [DB-1:0] wb;
   logic [PW-1:0] ep;
   logic [31:0]   ra, rd;
   logic [15:0]   et;
   logic [7:0]    ip;
   int            e_exp, nw, c0;

   initial begin
      tbl[0] = '{2'b11, 32'h0000_0010, 32'h0000_00AA, 1'b1, 1'b0};
      tbl[1] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0};
      tbl[2] = '{2'b00, 32'h0000_0055, 32'h0000_0066, 1'b0, 1'b1};
      tbl[3] = '{2'b11, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
      tbl[4] = '{2'b11, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 1'b1, 1'b0};
      tbl[5] = '{2'b11, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0};
      tbl[6] = '{2'b10, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0};
      tbl[7] = '{2'b11, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1};
      pv = 1'b0; pkt = '0; pv_b = 1'b0; pkt_b = '0; inport = '0;
      phv_ready = 1'b1; phv_ready_b = 1'b1; rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_pkt_valid", 160'(pkt_valid), 160'(0));
      chk("rst_phv_valid", 160'(phv_valid), 160'(0));
      chk("rst_phv_any", 160'(|phv), 160'(0));
      chk("rst_wren", 160'(wren), 160'(0));
      chk("rst_err", 160'(err_cnt), 160'(0));
      chk("rst_drop", 160'(drop_cnt), 160'(0));
      chk("rst_in_ready", 160'(in_ready), 160'(1));
      chk("rst_b_in_ready", 160'(in_ready_b), 160'(1));
      chk("rst_b_wren", 160'(wren_b), 160'(0));

      // 3-word data packet, port sampled on the head only
      do_reset;
      w0 = hd(16'h0800, {4{32'h1111_2222}}); w1 = {4{32'h3333_4444}}; w2 = {4{32'h5555_6666}};
      inport = 8'h05;
      send(2'b01, w0); c0 = acc_cyc;
      inport = 8'h09;
      send(2'b11, w1);
      send(2'b10, w2);
      chk("t1_phv_valid", 160'(phv_valid), 160'(1));
      @(posedge clk); #1;
      chk("t1_phv_valid_drop", 160'(phv_valid), 160'(0));
      repeat (3) @(negedge clk);
      chk("t1_pkt_n", 160'(got_pkt.size()), 160'(3));
      if (got_pkt.size() == 3) begin
         chk("t1_pkt0", 160'(got_pkt[0].w), 160'({2'b01, 4'hF, w0}));
         chk("t1_pkt1", 160'(got_pkt[1].w), 160'({2'b11, 4'hF, w1}));
         chk("t1_pkt2", 160'(got_pkt[2].w), 160'({2'b10, 4'hF, w2}));
         chk("t1_latency", 160'(got_pkt[0].c), 160'(c0 + 1));
      end
      pw.delete(); pw.push_back(w0); pw.push_back(w1); pw.push_back(w2);
      chk("t1_phv_n", 160'(got_phv.size()), 160'(1));
      if (got_phv.size() == 1) chk_phv("t1_phv", got_phv[0], mkphv(8'h05));

      // held PHV while consumer stalls, second PHV dropped
      do_reset;
      phv_ready = 1'b0;
      inport = 8'h03;
      w0 = hd(16'h86DD, {4{32'hA0A0_0101}}); w1 = {4{32'hA1A1_0202}};
      send(2'b01, w0); send(2'b10, w1);
      pw.delete(); pw.push_back(w0); pw.push_back(w1);
      ep = mkphv(8'h03);
      inport = 8'h04;
      send(2'b01, hd(16'h0800, {4{32'hB0B0_B0B0}})); send(2'b11, rnd_w()); send(2'b10, rnd_w());
      repeat (2) @(negedge clk);
      chk("t2_held_valid", 160'(phv_valid), 160'(1));
      chk_phv("t2_held", phv, ep);
      chk("t2_drop", 160'(drop_cnt), 160'(1));
      @(posedge clk); #1 phv_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("t2_valid_after", 160'(phv_valid), 160'(0));
      chk("t2_phv_n", 160'(got_phv.size()), 160'(1));
      if (got_phv.size() == 1) chk_phv("t2_xfer", got_phv[0], ep);

      // config packet with two rules, nothing forwarded
      do_reset;
      send(2'b01, hd(16'h9006, rnd_w()));
      send(2'b11, cw(32'h10, 32'hAA)); c0 = acc_cyc;
      send(2'b10, cw(32'h20, 32'hBB));
      repeat (3) @(negedge clk);
      chk("t3_rule_n", 160'(got_rule.size()), 160'(2));
      if (got_rule.size() == 2) begin
         chk("t3_r0", 160'({got_rule[0].a, got_rule[0].d}), 160'({32'h10, 32'hAA}));
         chk("t3_r1", 160'({got_rule[1].a, got_rule[1].d}), 160'({32'h20, 32'hBB}));
         chk("t3_r0_cyc", 160'(got_rule[0].c), 160'(c0 + 1));
      end
      chk("t3_no_fwd", 160'(got_pkt.size()), 160'(0));
      chk("t3_err", 160'(err_cnt), 160'(0));

      // table of single config words inside one config packet
      do_reset;
      send(2'b01, hd(16'h9006, '0));
      e_exp = 0;
      for (int i = 0; i < 8; i++) begin
         send(tbl[i].tag, cw(tbl[i].a, tbl[i].d));
         if (tbl[i].e) e_exp++;
         chk($sformatf("tbl%0d_wren", i), 160'(wren), 160'(tbl[i].w));
         if (tbl[i].w) chk($sformatf("tbl%0d_rule", i), 160'({addr, wdata}), 160'({tbl[i].a, tbl[i].d}));
         chk($sformatf("tbl%0d_err", i), 160'(err_cnt), 160'(e_exp));
         chk($sformatf("tbl%0d_fwd", i), 160'(pkt_valid), 160'(0));
      end

      // three rule slots, middle one skipped, upstream held during serialization
      do_reset;
      wb = '0; wb[31:16] = 16'h9006;
      send_b(2'b01, wb);
      wb = '0;
      wb[47:16] = 32'h100; wb[79:48] = 32'h1;
      wb[111:80] = 32'hFFFF_FFFF; wb[143:112] = 32'hEE;
      wb[175:144] = 32'h300; wb[207:176] = 32'h3;
      send_b(2'b11, wb); c0 = acc_cyc;
      wb = '1;
      wb[47:16] = 32'h400; wb[79:48] = 32'h4;
      send_b(2'b10, wb);
      repeat (4) @(negedge clk);
      chk("t4_rule_n", 160'(got_rule_b.size()), 160'(3));
      if (got_rule_b.size() == 3) begin
         chk("t4_r0", 160'({got_rule_b[0].a, got_rule_b[0].d, got_rule_b[0].c}), 160'({32'h100, 32'h1, c0 + 1}));
         chk("t4_r1", 160'({got_rule_b[1].a, got_rule_b[1].d, got_rule_b[1].c}), 160'({32'h300, 32'h3, c0 + 2}));
         chk("t4_r2", 160'({got_rule_b[2].a, got_rule_b[2].d, got_rule_b[2].c}), 160'({32'h400, 32'h4, c0 + 3}));
      end
      chk("t4_ready_low", 160'(ir_low_b), 160'(1));

      // stray body, then head/body/head/tail: only the second packet yields a PHV
      do_reset;
      send(2'b11, rnd_w());
      inport = 8'h01;
      send(2'b01, hd(16'h0800, rnd_w())); send(2'b11, rnd_w());
      inport = 8'h02;
      w0 = hd(16'h0800, rnd_w()); w1 = rnd_w();
      send(2'b01, w0); send(2'b10, w1);
      repeat (3) @(negedge clk);
      chk("t5_err", 160'(err_cnt), 160'(2));
      chk("t5_phv_n", 160'(got_phv.size()), 160'(1));
      pw.delete(); pw.push_back(w0); pw.push_back(w1);
      if (got_phv.size() == 1) chk_phv("t5_phv", got_phv[0], mkphv(8'h02));

      // reset in the middle of a data packet
      do_reset;
      inport = 8'h07;
      send(2'b01, hd(16'h0800, rnd_w())); send(2'b11, rnd_w());
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      chk("t6_pkt", 160'({pkt_valid, pkt_out}), 160'(0));
      chk("t6_phv", 160'({phv_valid, |phv}), 160'(0));
      chk("t6_rule", 160'({wren, addr, wdata}), 160'(0));
      chk("t6_cnt", 160'({err_cnt, drop_cnt}), 160'(0));
      chk("t6_ready", 160'(in_ready), 160'(1));
      got_phv.delete();
      send(2'b11, rnd_w()); send(2'b10, rnd_w());
      repeat (3) @(negedge clk);
      chk("t6_phv_n", 160'(got_phv.size()), 160'(0));
      chk("t6_err", 160'(err_cnt), 160'(2));

      // random packets against the whole-packet model
      do_reset;
      exp_pkt.delete(); exp_phv.delete(); exp_rule.delete();
      for (int p = 0; p < 40; p++) begin
         if ($urandom_range(0, 3) == 0) begin
            send(2'b01, hd(16'h9006, rnd_w()));
            nw = $urandom_range(1, 3);
            for (int j = 0; j < nw; j++) begin
               ra = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : $urandom;
               rd = $urandom;
               w0 = rnd_w(); w0[47:16] = ra; w0[79:48] = rd;
               send(j == nw - 1 ? 2'b10 : 2'b11, w0);
               if (ra != 32'hFFFF_FFFF) exp_rule.push_back({ra, rd});
            end
         end else begin
            nw = $urandom_range(2, 10);
            ip = 8'($urandom);
            et = 16'($urandom);
            if (et == 16'h9006) et = 16'h0800;
            pw.delete();
            inport = ip;
            for (int j = 0; j < nw; j++) begin
               w0 = j == 0 ? hd(et, rnd_w()) : rnd_w();
               w3 = {124'h0, 4'($urandom)};
               pw.push_back(w0);
               send(j == 0 ? 2'b01 : (j == nw - 1 ? 2'b10 : 2'b11), w0, w3[3:0]);
               exp_pkt.push_back({j == 0 ? 2'b01 : (j == nw - 1 ? 2'b10 : 2'b11), w3[3:0], w0});
               inport = 8'($urandom);
            end
            exp_phv.push_back(mkphv(ip));
         end
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      repeat (5) @(negedge clk);
      chk("rnd_pkt_n", 160'(got_pkt.size()), 160'(exp_pkt.size()));
      chk("rnd_phv_n", 160'(got_phv.size()), 160'(exp_phv.size()));
      chk("rnd_rule_n", 160'(got_rule.size()), 160'(exp_rule.size()));
      for (int i = 0; i < got_pkt.size() && i < exp_pkt.size(); i++)
         chk($sformatf("rnd_pkt%0d", i), 160'(got_pkt[i].w), 160'(exp_pkt[i]));
      for (int i = 0; i < got_phv.size() && i < exp_phv.size(); i++)
         chk_phv($sformatf("rnd_phv%0d", i), got_phv[i], exp_phv[i]);
      for (int i = 0; i < got_rule.size() && i < exp_rule.size(); i++)
         chk($sformatf("rnd_rule%0d", i), 160'({got_rule[i].a, got_rule[i].d}), 160'(exp_rule[i]));
      chk("rnd_err", 160'(err_cnt), 160'(0));
      chk("rnd_drop", 160'(drop_cnt), 160'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/gen_phv_conf_parser_v2.md
Name: gen_phv_conf_parser_v2

Overview:
Parametrised successor of the single-channel PHV generator and configuration parser. It takes the packet word stream, forwards data packets with one cycle of latency, and builds a PHV_WIDTH-bit PHV from the leading words. The PHV leaves on a valid/ready handshake. Configuration packets are identified by CONF_ETYPE, consumed, and turned into serialized rule writes, with several rules per word and input back-pressure.

Parameters:
DW, 128, data bits per word; each word is DW+6 bits.
PHV_WIDTH, 1024, PHV width; must be a multiple of DW.
PKT_NUM, PHV_WIDTH/DW, maximum number of words captured into the PHV.
CONF_ETYPE, 16'h9006, EtherType at head-word data[31:16] that marks a config packet.
RULE_PER_WORD, 1, rule slots per config word; 16+64*RULE_PER_WORD must be <= DW.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_pkt_valid  in  1  input word valid
i_pkt  in  DW+6  [DW+5:DW+4] tag (01 head, 11 body, 10 tail, 00 invalid), [DW+3:DW] byte-valid, [DW-1:0] data
o_in_ready  out  1  word accepted when i_pkt_valid & o_in_ready
i_inport  in  8  ingress port, sampled on the head word
o_pkt_valid  out  1  forwarded word valid
o_pkt  out  DW+6  forwarded word
o_phv_valid  out  1  PHV valid; held until accepted
i_phv_ready  in  1  PHV consumer ready
o_phv  out  PHV_WIDTH  PHV
o_rule_wren  out  1  rule write strobe, one cycle
o_rule_addr  out  32  rule address
o_rule_wdata  out  32  rule data
o_err_cnt  out  16  saturating protocol-error count
o_phv_drop_cnt  out  16  saturating dropped-PHV count

Behaviour:
- Reset (sync, i_rst=1): all valid and wren outputs 0, o_phv 0, counters 0, FSM to IDLE, o_in_ready 1. Reset mid-packet discards the packet; no PHV or rule write is produced from it.
- States: IDLE, DATA, CONF, CONF_SER.
- IDLE:
  - Head word, data[31:16]==CONF_ETYPE -> CONF.
  - Head word, any other EtherType -> DATA.
  - Body/tail word -> ignored, err_cnt+1.
  - Tag 00 in any state -> ignored, err_cnt+1.
- DATA:
  - Every accepted word appears on o_pkt/o_pkt_valid exactly one cycle later, unmodified.
  - Head word: clears the PHV build buffer, writes data into the top DW bits, and writes i_inport into bits [15:8]. Word count = 1.
  - Word n (n = 1..PKT_NUM-1): data goes to bits [PHV_WIDTH-1-DW*n -: DW]. Words beyond PKT_NUM are forwarded but not captured. Bits [15:8] always keep inport; a later word overwrites only its own slice except [15:8].
  - Tail -> IDLE. The PHV is emitted the cycle after the tail is accepted.
  - Head while in DATA (missing tail): err_cnt+1, the partial PHV is discarded, and a new packet starts (DATA or CONF by EtherType).
- PHV handshake:
  - o_phv_valid/o_phv hold stable until i_phv_ready=1; the transfer happens on that cycle.
  - If a new PHV completes while o_phv_valid=1 and i_phv_ready=0, the new PHV is dropped, phv_drop_cnt+1, and the held PHV is unchanged.
  - If i_phv_ready=1 on the same cycle a new PHV completes, the old one transfers and the new one loads (no drop).
- CONF:
  - Config words are never forwarded (o_pkt_valid stays 0); the head carries no rules.
  - Each accepted body/tail word is latched. Slot k (k = 0..RULE_PER_WORD-1): addr = data[16+64k +: 32], wdata = data[48+64k +: 32].
  - Slots with addr == 32'hFFFF_FFFF are skipped.
  - The first valid slot is emitted the cycle after acceptance.
  - If further valid slots remain, the FSM enters CONF_SER, o_in_ready=0, and one slot is emitted per cycle in ascending k. o_in_ready rises in the cycle the last slot is emitted.
  - After the tail's slots are done -> IDLE.
  - RULE_PER_WORD=1: CONF_SER is never entered and o_in_ready stays 1.
  - Head in CONF: err_cnt+1, then treated as a new packet.
- Counters saturate at 16'hFFFF.
- o_in_ready is 0 only in CONF_SER. Upstream must hold i_pkt stable while it is low.

Test Plan:
1. Data packet of 3 words (head EtherType 0x0800, i_inport=8'h05), i_phv_ready=1 -> o_pkt is an identical 3-word copy delayed 1 cycle; o_phv_valid for 1 cycle, 1 cycle after the tail; o_phv top 3×DW bits = data words, [15:8]=8'h05, remaining bits 0.
2. Two back-to-back data packets, i_phv_ready=0 throughout -> first PHV held stable, phv_drop_cnt=1; then i_phv_ready=1 -> first PHV transfers and o_phv_valid drops.
3. Config packet: head 0x9006 plus 2 words, RULE_PER_WORD=1, addr/data (0x10/0xAA) and (0x20/0xBB) -> exactly two wren pulses with those values; o_pkt_valid never 1.
4. DW=256, RULE_PER_WORD=3, one config word with slot 1 addr=FFFFFFFF -> wren on 2 consecutive cycles (slots 0, then 2); o_in_ready low 1 cycle; word held by upstream is not lost.
5. Body word in IDLE, then head, body, head, tail -> err_cnt=2; only the second packet's PHV is emitted.
6. i_rst=1 mid data packet, then remaining body and tail words -> no PHV, err_cnt=2 (body and tail arriving in IDLE), all outputs 0 the cycle after reset.
